alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a single multi-cycle ALU.
// One operation in flight at a time: accept, settle operands, pulse start,
// wait for the ALU result (or abort on timeout), then answer the requester.
module alu_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        soc_clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req0_dat1,
    input  logic [31:0] req0_dat2,
    input  logic [5:0]  req0_instr,
    input  logic [31:0] req1_dat1,
    input  logic [31:0] req1_dat2,
    input  logic [5:0]  req1_instr,
    output logic [1:0]  req_accept,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_out,
    output logic [3:0]  rsp_flags,
    output logic        rsp_timeout,
    output logic        dat_ready,
    output logic [31:0] ALU_dat1,
    output logic [31:0] ALU_dat2,
    output logic [5:0]  Instruction_from_CU,
    input  logic        ALU_ready,
    input  logic [31:0] ALU_out,
    input  logic        ALU_overflow,
    input  logic        ALU_con_met,
    input  logic        ALU_zero,
    input  logic        ALU_err
);

    // Counter is at least 8 bits and always wide enough to hold TIMEOUT.
    localparam int unsigned CW_RAW = $clog2(TIMEOUT + 1);
    localparam int unsigned CW     = (CW_RAW > 8) ? CW_RAW : 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          ptr;
    logic          winner;
    logic          pick;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          timeout_hit;

    // Requester 1 wins when it is alone, or when both ask and the pointer names it.
    assign pick        = req_valid[1] & (~req_valid[0] | ptr);
    assign cnt_inc     = cnt + CW'(1);
    // Abort once TIMEOUT full cycles have been spent in WAIT without a result.
    assign timeout_hit = (cnt_inc == CW'(TIMEOUT));

    // State register.
    always_ff @(posedge soc_clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake pulses; accept is qualified by reset so every output is 0 while held in reset.
    always_comb begin
        state_next = state;
        req_accept = '0;
        dat_ready  = 1'b0;
        rsp_valid  = '0;
        case (state)
            IDLE: begin
                if (reset && (|req_valid)) begin
                    req_accept = pick ? 2'b10 : 2'b01;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = PULSE;
            end
            PULSE: begin
                dat_ready  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (ALU_ready || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid  = winner ? 2'b10 : 2'b01;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch, arbitration pointer, wait counter and response capture.
    always_ff @(posedge soc_clk or negedge reset) begin
        if (!reset) begin
            ptr                 <= 1'b0;
            winner              <= 1'b0;
            cnt                 <= '0;
            ALU_dat1            <= '0;
            ALU_dat2            <= '0;
            Instruction_from_CU <= '0;
            rsp_out             <= '0;
            rsp_flags           <= '0;
            rsp_timeout         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        winner <= pick;
                        if (pick) begin
                            ALU_dat1            <= req1_dat1;
                            ALU_dat2            <= req1_dat2;
                            Instruction_from_CU <= req1_instr;
                        end else begin
                            ALU_dat1            <= req0_dat1;
                            ALU_dat2            <= req0_dat2;
                            Instruction_from_CU <= req0_instr;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt_inc;
                    if (ALU_ready) begin
                        rsp_out     <= ALU_out;
                        rsp_flags   <= {ALU_err, ALU_zero, ALU_con_met, ALU_overflow};
                        rsp_timeout <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_out     <= '0;
                        rsp_flags   <= '0;
                        rsp_timeout <= 1'b1;
                    end
                end
                RESP: begin
                    cnt <= '0;
                    ptr <= ~winner;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table of single transactions plus
// hand-written sequences for round-robin, timeout, reset and spurious ready.
module tb_alu_arbiter;

    localparam int unsigned TO = 64;

    logic        soc_clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [31:0] req0_dat1, req0_dat2, req1_dat1, req1_dat2;
    logic [5:0]  req0_instr, req1_instr;
    logic [1:0]  req_accept, rsp_valid;
    logic [31:0] rsp_out;
    logic [3:0]  rsp_flags;
    logic        rsp_timeout, dat_ready;
    logic [31:0] ALU_dat1, ALU_dat2;
    logic [5:0]  Instruction_from_CU;
    logic        ALU_ready;
    logic [31:0] ALU_out;
    logic        ALU_overflow, ALU_con_met, ALU_zero, ALU_err;

    logic [111:0] outs;
    assign outs = {req_accept, rsp_valid, rsp_out, rsp_flags, rsp_timeout,
                   dat_ready, ALU_dat1, ALU_dat2, Instruction_from_CU};

    alu_arbiter #(.TIMEOUT(TO)) dut (
        .soc_clk(soc_clk), .reset(reset), .req_valid(req_valid),
        .req0_dat1(req0_dat1), .req0_dat2(req0_dat2), .req0_instr(req0_instr),
        .req1_dat1(req1_dat1), .req1_dat2(req1_dat2), .req1_instr(req1_instr),
        .req_accept(req_accept), .rsp_valid(rsp_valid), .rsp_out(rsp_out),
        .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout), .dat_ready(dat_ready),
        .ALU_dat1(ALU_dat1), .ALU_dat2(ALU_dat2),
        .Instruction_from_CU(Instruction_from_CU), .ALU_ready(ALU_ready),
        .ALU_out(ALU_out), .ALU_overflow(ALU_overflow), .ALU_con_met(ALU_con_met),
        .ALU_zero(ALU_zero), .ALU_err(ALU_err)
    );

    typedef struct {
        logic [1:0]  rv;
        logic [31:0] a0, b0;
        logic [5:0]  i0;
        logic [31:0] a1, b1;
        logic [5:0]  i1;
        logic [31:0] aout;
        logic [3:0]  aflags;   // {err, zero, con_met, overflow}
        int          delay;    // WAIT cycles before ALU_ready
        logic [1:0]  exp_acc;
        logic [31:0] exp_d1, exp_d2;
        logic [5:0]  exp_i;
    } vec_t;

    vec_t tbl[5];
    vec_t h;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc = 0;

    initial soc_clk = 1'b0;
    always #5 soc_clk = ~soc_clk;
    always @(posedge soc_clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "simulation did not terminate");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input vec_t v);
        req_valid  = v.rv;
        req0_dat1  = v.a0;  req0_dat2 = v.b0;  req0_instr = v.i0;
        req1_dat1  = v.a1;  req1_dat2 = v.b1;  req1_instr = v.i1;
        ALU_ready  = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge soc_clk); #1;
        reset     = 1'b0;
        req_valid = 2'b11;
        ALU_ready = 1'b1;
        @(negedge soc_clk);
        chk("reset_outputs", 128'(outs), 128'd0);
        @(posedge soc_clk); #1;
        reset     = 1'b1;
        req_valid = 2'b00;
        ALU_ready = 1'b0;
    endtask

    // Full transaction; called at posedge+1 with the DUT in IDLE.
    task automatic run_txn(input vec_t v, input bit hold, input bit chk_gap);
        int n;
        drive_req(v);
        n = 0;
        @(negedge soc_clk);
        while (req_accept == 2'b00 && n < 20) begin
            @(negedge soc_clk);
            n++;
        end
        chk("accept", 128'(req_accept), 128'(v.exp_acc));
        chk("accept_rsp_quiet", 128'(rsp_valid), 128'd0);
        if (chk_gap) chk("accept_gap", 128'(cyc - last_acc), 128'd5);
        last_acc = cyc;
        @(posedge soc_clk); #1;
        if (!hold) begin
            // Operands must already be latched; changes after accept are ignored.
            req_valid = 2'b00;
            req0_dat1 = ~req0_dat1; req0_dat2 = ~req0_dat2; req0_instr = ~req0_instr;
            req1_dat1 = ~req1_dat1; req1_dat2 = ~req1_dat2; req1_instr = ~req1_instr;
        end
        @(negedge soc_clk);
        chk("setup_dat_ready", 128'(dat_ready), 128'd0);
        chk("alu_dat1", 128'(ALU_dat1), 128'(v.exp_d1));
        chk("alu_dat2", 128'(ALU_dat2), 128'(v.exp_d2));
        chk("alu_instr", 128'(Instruction_from_CU), 128'(v.exp_i));
        @(negedge soc_clk);
        chk("pulse_dat_ready", 128'(dat_ready), 128'd1);
        @(posedge soc_clk); #1;
        repeat (v.delay) begin
            @(posedge soc_clk); #1;
        end
        ALU_ready = 1'b1;
        ALU_out   = v.aout;
        {ALU_err, ALU_zero, ALU_con_met, ALU_overflow} = v.aflags;
        @(negedge soc_clk);
        chk("wait_no_rsp", 128'({rsp_valid, dat_ready}), 128'd0);
        @(posedge soc_clk); #1;
        ALU_ready = 1'b0;
        ALU_out   = ~v.aout;
        {ALU_err, ALU_zero, ALU_con_met, ALU_overflow} = ~v.aflags;
        @(negedge soc_clk);
        chk("rsp_valid", 128'(rsp_valid), 128'(v.exp_acc));
        chk("rsp_out", 128'(rsp_out), 128'(v.aout));
        chk("rsp_flags", 128'(rsp_flags), 128'(v.aflags));
        chk("rsp_timeout", 128'(rsp_timeout), 128'd0);
        chk("rsp_no_accept", 128'(req_accept), 128'd0);
        chk("rsp_operands_held", 128'(ALU_dat1), 128'(v.exp_d1));
        @(posedge soc_clk); #1;
    endtask

    initial begin
        int n;
        reset = 1'b0;
        req_valid = '0;
        req0_dat1 = '0; req0_dat2 = '0; req0_instr = '0;
        req1_dat1 = '0; req1_dat2 = '0; req1_instr = '0;
        ALU_ready = 1'b0; ALU_out = '0;
        ALU_overflow = 1'b0; ALU_con_met = 1'b0; ALU_zero = 1'b0; ALU_err = 1'b0;

        //          rv     a0            b0            i0  a1            b1            i1  aout          flags    dly exp    d1            d2            i
        tbl[0] = '{2'b01, 32'd10,       32'd5,        6'd27, 32'hAAAA0001, 32'hAAAA0002, 6'd9,  32'd15,       4'b0000, 1, 2'b01, 32'd10,       32'd5,        6'd27};
        tbl[1] = '{2'b10, 32'h11,       32'h22,       6'd3,  32'd5,        32'd5,        6'd4,  32'd0,        4'b0110, 0, 2'b10, 32'd5,        32'd5,        6'd4};
        tbl[2] = '{2'b11, 32'hFFFFFFFF, 32'd1,        6'd1,  32'h100,      32'h200,      6'd2,  32'd0,        4'b0101, 3, 2'b01, 32'hFFFFFFFF, 32'd1,        6'd1};
        tbl[3] = '{2'b11, 32'h3,        32'h4,        6'd7,  32'h12345678, 32'h0F0F0F0F, 6'd63, 32'hDEADBEEF, 4'b1000, 2, 2'b10, 32'h12345678, 32'h0F0F0F0F, 6'd63};
        tbl[4] = '{2'b11, 32'd7,        32'd9,        6'd5,  32'hCAFE,     32'hF00D,     6'd12, 32'h80000000, 4'b0010, 5, 2'b01, 32'd7,        32'd9,        6'd5};

        apply_reset();
        for (int i = 0; i < 5; i++) run_txn(tbl[i], 1'b0, 1'b0);

        // Both requesters held high: grants alternate 01, 10, 01 back to back.
        apply_reset();
        h = '{2'b11, 32'h1000, 32'h2000, 6'd10, 32'h3000, 32'h4000, 6'd11,
              32'h55, 4'b0000, 0, 2'b01, 32'h1000, 32'h2000, 6'd10};
        run_txn(h, 1'b1, 1'b0);
        h.exp_acc = 2'b10; h.exp_d1 = 32'h3000; h.exp_d2 = 32'h4000; h.exp_i = 6'd11;
        run_txn(h, 1'b1, 1'b1);
        h.exp_acc = 2'b01; h.exp_d1 = 32'h1000; h.exp_d2 = 32'h2000; h.exp_i = 6'd10;
        run_txn(h, 1'b1, 1'b1);
        req_valid = 2'b00;

        // Timeout: ALU never answers; response follows TO full WAIT cycles.
        h = '{2'b01, 32'd1, 32'd2, 6'd3, 32'd4, 32'd5, 6'd6,
              32'd0, 4'b0000, 0, 2'b01, 32'd1, 32'd2, 6'd3};
        drive_req(h);
        n = 0;
        @(negedge soc_clk);
        while (req_accept == 2'b00 && n < 20) begin
            @(negedge soc_clk);
            n++;
        end
        chk("to_accept", 128'(req_accept), 128'd1);
        @(posedge soc_clk); #1;
        req_valid = 2'b00;
        @(negedge soc_clk);
        @(negedge soc_clk);
        chk("to_dat_ready", 128'(dat_ready), 128'd1);
        n = 0;
        do begin
            @(negedge soc_clk);
            n++;
        end while (rsp_valid == 2'b00 && n < 200);
        chk("to_latency", 128'(n), 128'(TO + 1));
        chk("to_rsp_valid", 128'(rsp_valid), 128'd1);
        chk("to_flag", 128'(rsp_timeout), 128'd1);
        chk("to_rsp_out", 128'(rsp_out), 128'd0);
        chk("to_rsp_flags", 128'(rsp_flags), 128'd0);
        @(posedge soc_clk); #1;

        // Reset in WAIT: pointer now favours requester 1; reset must restore requester 0 priority.
        h = '{2'b11, 32'hA, 32'hB, 6'd1, 32'hC, 32'hD, 6'd2,
              32'd0, 4'b0000, 0, 2'b10, 32'hC, 32'hD, 6'd2};
        drive_req(h);
        @(negedge soc_clk);
        chk("rw_accept", 128'(req_accept), 128'd2);
        @(posedge soc_clk); #1;
        req_valid = 2'b00;
        repeat (3) begin
            @(posedge soc_clk); #1;
        end
        reset = 1'b0;
        @(negedge soc_clk);
        chk("rw_outputs", 128'(outs), 128'd0);
        @(posedge soc_clk); #1;
        reset = 1'b1;
        n = 0;
        repeat (4) begin
            @(negedge soc_clk);
            if (rsp_valid != 2'b00) n++;
        end
        chk("rw_no_rsp", 128'(n), 128'd0);
        @(posedge soc_clk); #1;
        h = '{2'b11, 32'h21, 32'h22, 6'd13, 32'h31, 32'h32, 6'd14,
              32'h77, 4'b0001, 1, 2'b01, 32'h21, 32'h22, 6'd13};
        run_txn(h, 1'b0, 1'b0);

        // Spurious ALU_ready while idle changes nothing.
        ALU_ready = 1'b1;
        ALU_out   = 32'h99999999;
        {ALU_err, ALU_zero, ALU_con_met, ALU_overflow} = 4'b1110;
        repeat (3) begin
            @(negedge soc_clk);
            chk("sp_no_rsp", 128'(rsp_valid), 128'd0);
            chk("sp_rsp_out", 128'(rsp_out), 128'h77);
            chk("sp_rsp_flags", 128'(rsp_flags), 128'b0001);
        end
        @(posedge soc_clk); #1;
        ALU_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
